led_pulse_stretcher: RTL and testbench
======================================

// Module: led_pulse_stretcher
// PURPOSE
//   Output-side counterpart to button input conditioning.
//   Turns 1-cycle core event strobes (UART rx, trap, bus error) into human-visible LED blinks.
//   Each blink has a guaranteed minimum ON time and a minimum OFF gap.
//   Events that arrive during a blink are counted and replayed as separate blinks, so none are merged or lost until the counter saturates.
//   Sits between the core's status strobes and the board LED pins.
// PARAMETERS
//   ON_CYCLES   12_000_000  LED-on duration per blink, in clk cycles; must be >= 1
//   OFF_CYCLES  6_000_000   forced LED-off gap after each blink, in clk cycles; must be >= 1
//   PEND_W      3           width of pending-event counter; max queued = 2^PEND_W-1
// PORTS
//   clk             in   1       system clock
//   reset           in   1       synchronous, active-high reset
//   event_in        in   1       event strobe; every cycle it is high counts as one event
//   clear_overflow  in   1       clears sticky overflow flag
//   led_out         out  1       registered LED drive, 1 = lit
//   busy            out  1       1 while state != IDLE
//   pending         out  PEND_W  number of queued events not yet shown
//   overflow        out  1       sticky: an event was dropped because pending was saturated
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous and active-high on port reset.
//   - Reset: state=IDLE, timer=0, led_out=0, busy=0, pending=0, overflow=0.
//     Reset wins over all other inputs; event_in during reset is ignored.
//     Reset asserted mid-blink aborts the blink, and led_out=0 on the next edge.
//   - State machine: IDLE, ON, OFF. Down-counter timer of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
//   - IDLE: led_out=0.
//     event_in=1 -> ON, timer=ON_CYCLES-1. pending is unchanged; the event is consumed directly.
//     Latency: strobe at cycle n gives led_out=1 at cycle n+1.
//   - ON: led_out=1 for exactly ON_CYCLES cycles.
//     timer!=0 -> decrement.
//     timer==0 -> OFF, timer=OFF_CYCLES-1.
//   - OFF: led_out=0 for exactly OFF_CYCLES cycles.
//     timer!=0 -> decrement.
//     timer==0 -> let eff = pending + event_in:
//       eff>0  -> ON, timer=ON_CYCLES-1, pending=eff-1. No IDLE cycle is inserted.
//       eff==0 -> IDLE.
//   - event_in in ON, or in OFF with timer!=0:
//       pending<max  -> pending+1.
//       pending==max -> event dropped, overflow<=1.
//   - overflow stays 1 until clear_overflow=1 or reset.
//     If clear_overflow and a new drop occur in the same cycle, the drop wins (overflow=1).
//   - busy = (state != IDLE), registered together with state.
//   - All outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING  (ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2)
//   1. Single event_in pulse at cycle 10 ->
//      led_out=1 cycles 11-14, 0 cycles 15-16;
//      busy=1 cycles 11-16, 0 from 17; pending stays 0.
//   2. Events at cycles 10, 12, 13 ->
//      pending=2 after 13; blinks ON at 11-14, 17-20, 23-26;
//      pending=1 at 17, 0 at 23; busy falls at 29.
//   3. Five events during the first ON window ->
//      pending saturates at 3, overflow=1;
//      clear_overflow pulse -> overflow=0 while pending still counts down normally.
//   4. pending=0 and event_in on the last OFF cycle (timer==0) ->
//      led_out=1 on the very next cycle, pending stays 0, busy never drops.
//   5. reset at cycle 12 of scenario 2, with event_in=1 in the same cycle ->
//      cycle 13: led_out=0, busy=0, pending=0, overflow=0;
//      no further blinks occur.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module   : led_pulse_stretcher
//  Purpose  : Stretches 1-cycle event strobes into visible LED blinks with a
//             minimum on time and off gap, queueing events that arrive mid-blink.
//  Revision : 1.0  initial release
// ============================================================================
module led_pulse_stretcher #(
    parameter int unsigned ON_CYCLES  = 12_000_000,
    parameter int unsigned OFF_CYCLES = 6_000_000,
    parameter int unsigned PEND_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              event_in,
    input  logic              clear_overflow,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned c_MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned c_TIMER_W    = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_TIMER_W-1:0] c_ON_LOAD   = c_TIMER_W'(ON_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_OFF_LOAD  = c_TIMER_W'(OFF_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE = c_TIMER_W'(1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_0   = '0;
    localparam logic [PEND_W-1:0]    c_PEND_MAX  = '1;
    localparam logic [PEND_W-1:0]    c_PEND_ONE  = PEND_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ON   = 2'd1;
    localparam logic [1:0] c_OFF  = 2'd2;

    logic [1:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [PEND_W-1:0]    r_pending;
    logic                 r_overflow;
    logic                 r_led;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic [c_TIMER_W-1:0] w_timer_nxt;
    logic [PEND_W-1:0]    w_pending_nxt;
    logic                 w_overflow_nxt;
    logic                 w_drop;
    logic                 w_led_nxt;
    logic                 w_busy_nxt;

    // State register; LED and busy are registered alongside state so every
    // output is a flop with no input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_timer    <= c_TIMER_0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
            r_led      <= w_led_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state, timer and pending-queue logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_pending_nxt = r_pending;
        w_drop        = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (event_in) begin
                    w_state_nxt = c_ON;
                    w_timer_nxt = c_ON_LOAD;
                end
            end

            c_ON: begin
                if (r_timer != c_TIMER_0) begin
                    w_timer_nxt = r_timer - c_TIMER_ONE;
                end else begin
                    w_state_nxt = c_OFF;
                    w_timer_nxt = c_OFF_LOAD;
                end
                if (event_in) begin
                    if (r_pending != c_PEND_MAX) begin
                        w_pending_nxt = r_pending + c_PEND_ONE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end

            c_OFF: begin
                if (r_timer != c_TIMER_0) begin
                    w_timer_nxt = r_timer - c_TIMER_ONE;
                    if (event_in) begin
                        if (r_pending != c_PEND_MAX) begin
                            w_pending_nxt = r_pending + c_PEND_ONE;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end else if ((r_pending != '0) || event_in) begin
                    // A strobe on the last gap cycle is consumed directly by the
                    // next blink; otherwise one queued event is used up.
                    w_state_nxt = c_ON;
                    w_timer_nxt = c_ON_LOAD;
                    if (!event_in) begin
                        w_pending_nxt = r_pending - c_PEND_ONE;
                    end
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_timer_nxt = c_TIMER_0;
            end
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clear_overflow) begin
            w_overflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt = r_overflow;
        end
    end

    // Output decode from the upcoming state.
    always_comb begin
        w_led_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            c_ON: begin
                w_led_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
            end
            c_OFF: begin
                w_busy_nxt = 1'b1;
            end
            default: begin
                w_led_nxt  = 1'b0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign led_out  = r_led;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pulse_stretcher
//  Purpose  : Directed self-checking bench for led_pulse_stretcher using
//             per-cycle stimulus masks and hand-computed expected masks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pulse_stretcher;

    localparam int unsigned c_ON   = 4;
    localparam int unsigned c_OFF  = 2;
    localparam int unsigned c_PW   = 2;

    logic            clk;
    logic            reset;
    logic            event_in;
    logic            clear_overflow;
    logic            led_out;
    logic            busy;
    logic [c_PW-1:0] pending;
    logic            overflow;

    int n_vec;
    int n_err;

    led_pulse_stretcher #(
        .ON_CYCLES  (c_ON),
        .OFF_CYCLES (c_OFF),
        .PEND_W     (c_PW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .event_in       (event_in),
        .clear_overflow (clear_overflow),
        .led_out        (led_out),
        .busy           (busy),
        .pending        (pending),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compared word is {led_out, busy, pending[1], pending[0], overflow}.
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {led,busy,pend,ovf}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each mask bit c describes cycle c: stimulus bits are driven during
    // cycle c, expected bits are the registered outputs seen during cycle c.
    task automatic run(input string tag,
                       input logic [63:0] ev, input logic [63:0] rst, input logic [63:0] clr,
                       input logic [63:0] led, input logic [63:0] bsy,
                       input logic [63:0] p1, input logic [63:0] p0,
                       input logic [63:0] ovf, input int ncyc);
        reset          = 1'b1;
        event_in       = 1'b1;
        clear_overflow = 1'b0;
        tick();
        tick();
        check({tag, " reset"}, {led_out, busy, pending, overflow}, 5'b00000);
        for (int c = 0; c < ncyc; c++) begin
            event_in       = ev[c];
            reset          = rst[c];
            clear_overflow = clr[c];
            tick();
            check($sformatf("%s c%0d", tag, c + 1), {led_out, busy, pending, overflow},
                  {led[c+1], bsy[c+1], p1[c+1], p0[c+1], ovf[c+1]});
        end
        event_in       = 1'b0;
        reset          = 1'b0;
        clear_overflow = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        event_in       = 1'b0;
        clear_overflow = 1'b0;

        // Single strobe: on 11-14, off gap 15-16, idle from 17.
        run("single", 64'h400, 64'h0, 64'h0,
            64'h7800, 64'h1F800, 64'h0, 64'h0, 64'h0, 24);

        // Strobes at 10,12,13: blinks 11-14, 17-20, 23-26; busy falls at 29.
        run("queued", 64'h3400, 64'h0, 64'h0,
            64'h079E_7800, 64'h1FFF_F800, 64'h1_C000, 64'h7E_2000, 64'h0, 34);

        // Strobes 10-14 saturate pending at 3 with one drop; clear at 16.
        run("saturate", 64'h7C00, 64'h0, 64'h1_0000,
            64'h1_E79E_7800, 64'h7_FFFF_F800, 64'h7F_E000, 64'h1F81_D000, 64'h1_8000, 40);

        // Same saturation; clear collides with the drop at 14, reset at 18.
        run("drop_vs_clr", 64'h7C00, 64'h4_0000, 64'h4000,
            64'h6_7800, 64'h7_F800, 64'h7_E000, 64'h1_D000, 64'h7_8000, 26);

        // Strobe on the final gap cycle (16) starts the next blink at once.
        run("back2back", 64'h1_0400, 64'h0, 64'h0,
            64'h1E_7800, 64'h7F_F800, 64'h0, 64'h0, 64'h0, 28);

        // Reset at 12 with a strobe in the same cycle aborts everything.
        run("reset_mid", 64'h1400, 64'h1000, 64'h0,
            64'h1800, 64'h1800, 64'h0, 64'h0, 64'h0, 24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
